// File: rtl/hier_pipe.sv
// hier_pipe: nested valid/ready register pipeline, DEPTH levels deep; HIER_PIPE_INVERT_EN makes each stage invert
module hier_pipe_stage #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    input  logic             down_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data
);
    logic             v;
    logic [WIDTH-1:0] d;
    logic             next_ready;
    logic [WIDTH-1:0] f_data;

`ifdef HIER_PIPE_INVERT_EN
    assign f_data = ~up_data;
`else
    assign f_data = up_data;
`endif

    // an empty stage, or one whose successor is draining, can take a new word
    assign up_ready = !v || next_ready;

    // load or clear when ready, otherwise hold both valid and data
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (up_ready) begin
            v <= up_valid;
            if (up_valid) d <= f_data;
        end
    end

    // each level instantiates the next one so netlist depth matches stage count
    if (LEVELS > 1) begin : g_next
        hier_pipe_stage #(.WIDTH(WIDTH), .LEVELS(LEVELS - 1)) u_next (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (v),
            .up_data    (d),
            .up_ready   (next_ready),
            .down_ready (down_ready),
            .down_valid (down_valid),
            .down_data  (down_data)
        );
    end else begin : g_last
        assign next_ready = down_ready;
        assign down_valid = v;
        assign down_data  = d;
    end
endmodule

module hier_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH + 1);

    logic in_fire;
    logic out_fire;

    hier_pipe_stage #(.WIDTH(WIDTH), .LEVELS(DEPTH)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (in_valid),
        .up_data    (in_data),
        .up_ready   (in_ready),
        .down_ready (out_ready),
        .down_valid (out_valid),
        .down_data  (out_data)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // track filled stages; the handshake keeps it within 0..DEPTH
    always_ff @(posedge clk) begin
        if (rst) occupancy <= '0;
        else occupancy <= (in_fire && !out_fire) ? occupancy + OW'(1) :
                          (!in_fire && out_fire) ? occupancy - OW'(1) : occupancy;
    end
endmodule

// File: tb/tb_hier_pipe.sv
// tb_hier_pipe: directed checks of hier_pipe handshake, latency, stalls, bubbles and flush
module tb_hier_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [2:0] occupancy;
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [7:0] in_data1 = '0;
    logic       out_valid1;
    logic [7:0] out_data1;
    logic [1:0] occupancy1;
    int n_assert = 0;
    int n_fail = 0;

    hier_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
    );

    hier_pipe #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1), .occupancy(occupancy1)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset for two cycles
        cyc();
        cyc();
        chk("rst_occ", occupancy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_ready3", in_ready1, 1);
        // single word latency, plus the odd-depth instance
        in_valid = 1'b1; in_data = 8'hA5;
        in_valid1 = 1'b1; in_data1 = 8'h0F;
        cyc();
        in_valid = 1'b0; in_valid1 = 1'b0;
        chk("lat_occ1", occupancy, 1);
        cyc();
        chk("lat_v1", out_valid, 0);
        cyc();
        chk("lat_v2", out_valid, 0);
        chk("d3_valid", out_valid1, 1);
`ifdef HIER_PIPE_INVERT_EN
        chk("d3_data", out_data1, 8'hF0);
`else
        chk("d3_data", out_data1, 8'h0F);
`endif
        cyc();
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'hA5);
        cyc();
        chk("lat_drain_valid", out_valid, 0);
        chk("lat_drain_occ", occupancy, 0);
        // back-to-back streaming
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            cyc();
            if (i < 4) chk("stream_fill_occ", occupancy, i);
            else begin
                chk("stream_occ", occupancy, 4);
                chk("stream_valid", out_valid, 1);
                chk("stream_data", out_data, i - 3);
            end
        end
        in_valid = 1'b0;
        for (int i = 14; i <= 16; i++) begin
            cyc();
            chk("stream_tail_valid", out_valid, 1);
            chk("stream_tail_data", out_data, i);
        end
        cyc();
        chk("empty_valid", out_valid, 0);
        chk("empty_occ", occupancy, 0);
        chk("empty_hold_data", out_data, 8'h10);
        // fill while stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11; #1; chk("fill_ready1", in_ready, 1); cyc();
        in_data = 8'h22; #1; chk("fill_ready2", in_ready, 1); cyc();
        in_data = 8'h33; #1; chk("fill_ready3", in_ready, 1); cyc();
        in_data = 8'h44; #1; chk("fill_ready4", in_ready, 1); cyc();
        in_data = 8'h55; #1;
        chk("full_ready", in_ready, 0);
        chk("full_occ", occupancy, 4);
        chk("full_head", out_data, 8'h11);
        cyc();
        chk("full_hold_occ", occupancy, 4);
        chk("full_hold_head", out_data, 8'h11);
        out_ready = 1'b1; #1;
        chk("full_release_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("swap_occ", occupancy, 4);
        chk("swap_data", out_data, 8'h22);
        cyc(); chk("full_drain33", out_data, 8'h33);
        cyc(); chk("full_drain44", out_data, 8'h44);
        cyc(); chk("full_drain55", out_data, 8'h55);
        cyc(); chk("full_drain_occ", occupancy, 0);
        // bubbles collapse under stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; cyc();
        in_valid = 1'b0; cyc();
        in_valid = 1'b1; in_data = 8'h22; cyc();
        in_valid = 1'b0; cyc(); cyc(); cyc();
        chk("bubble_occ", occupancy, 2);
        chk("bubble_valid", out_valid, 1);
        chk("bubble_head", out_data, 8'h11);
        out_ready = 1'b1;
        cyc();
        chk("bubble_second_valid", out_valid, 1);
        chk("bubble_second", out_data, 8'h22);
        cyc();
        chk("bubble_empty", out_valid, 0);
        // flush with reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77; cyc();
        in_data = 8'h88; cyc();
        in_data = 8'h99; cyc();
        in_valid = 1'b0;
        chk("flush_pre_occ", occupancy, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_data", out_data, 0);
        #1;
        chk("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("flush_no_out", out_valid, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
